// File: rtl/sample_decimator.sv
// sample_decimator: multi-channel ADC sample decimator in the sample clock domain.
// Reduces the per-cycle sample stream to one result per window of accepted
// samples, per channel: last sample, unsigned max, unsigned min, or (when the
// DECIM_AVG_EN macro is defined) a power-of-two boxcar average.
// Without DECIM_AVG_EN, mode 11 behaves as mode 00 and no sum accumulators exist.
module sample_decimator #(
  parameter int N        = 12,
  parameter int CH       = 2,
  parameter int RW       = 16,
  parameter int MAX_LOG2 = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [CH*N-1:0] d,
  input  logic [RW-1:0]   ratio,
  input  logic [1:0]      mode,
  input  logic            hold,
  output logic            out_valid,
  output logic [CH*N-1:0] q,
  output logic            busy
);

  localparam int AW = N + MAX_LOG2;

  logic [RW-1:0]   count_q, count_d;
  logic [RW-1:0]   ratioL_q, ratioL_d;
  logic [1:0]      modeL_q, modeL_d;
  logic [CH*N-1:0] maxAcc_q, maxAcc_d;
  logic [CH*N-1:0] minAcc_q, minAcc_d;
  logic [CH*N-1:0] result_q, result_d;
  logic            outValid_q, outValid_d;

  logic            windowStart;
  logic            closing;
  logic [RW-1:0]   effRatio;
  logic [1:0]      effMode;
  logic [RW-1:0]   lastIdx;
  logic [N-1:0]    sample, curMax, curMin, newMax, newMin, res;

`ifdef DECIM_AVG_EN
  logic [CH*AW-1:0] sumAcc_q, sumAcc_d;
  logic [AW-1:0]    curSum, newSum;
  logic [RW-1:0]    kExp;
`endif

  assign out_valid = outValid_q;
  assign q         = result_q;
  assign busy      = (count_q != '0);

  // Window bookkeeping and per-channel reduction; the first sample of a window
  // uses the live ratio/mode inputs and reloads every accumulator.
  always_comb begin
    windowStart = (count_q == '0);
    effRatio    = windowStart ? ratio : ratioL_q;
    effMode     = windowStart ? mode  : modeL_q;
    lastIdx     = (effRatio == '0) ? '0 : effRatio - RW'(1);
`ifdef DECIM_AVG_EN
    kExp = (effRatio > RW'(MAX_LOG2)) ? RW'(MAX_LOG2) : effRatio;
    if (effMode == 2'b11) begin
      lastIdx = (RW'(1) << kExp) - RW'(1);
    end
    sumAcc_d = sumAcc_q;
    curSum   = '0;
    newSum   = '0;
`endif
    closing    = in_valid && (count_q == lastIdx);
    ratioL_d   = (windowStart && in_valid) ? ratio : ratioL_q;
    modeL_d    = (windowStart && in_valid) ? mode  : modeL_q;
    count_d    = count_q;
    if (in_valid) begin
      count_d = closing ? '0 : count_q + RW'(1);
    end
    outValid_d = closing && !hold;
    maxAcc_d   = maxAcc_q;
    minAcc_d   = minAcc_q;
    result_d   = result_q;
    sample     = '0;
    curMax     = '0;
    curMin     = '0;
    newMax     = '0;
    newMin     = '0;
    res        = '0;
    for (int c = 0; c < CH; c++) begin
      sample = d[c*N +: N];
      curMax = maxAcc_q[c*N +: N];
      curMin = minAcc_q[c*N +: N];
      newMax = (windowStart || (sample > curMax)) ? sample : curMax;
      newMin = (windowStart || (sample < curMin)) ? sample : curMin;
`ifdef DECIM_AVG_EN
      curSum = sumAcc_q[c*AW +: AW];
      newSum = windowStart ? AW'(sample) : curSum + AW'(sample);
`endif
      if (in_valid) begin
        maxAcc_d[c*N +: N] = newMax;
        minAcc_d[c*N +: N] = newMin;
`ifdef DECIM_AVG_EN
        sumAcc_d[c*AW +: AW] = newSum;
`endif
      end
      case (effMode)
        2'b01:   res = newMax;
        2'b10:   res = newMin;
`ifdef DECIM_AVG_EN
        2'b11:   res = N'(newSum >> kExp);
`endif
        default: res = sample;
      endcase
      if (closing && !hold) begin
        result_d[c*N +: N] = res;
      end
    end
  end

  // State registers; reset drops any partial window and wins over in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      ratioL_q   <= ratio;
      modeL_q    <= mode;
      maxAcc_q   <= '0;
      minAcc_q   <= '1;
      result_q   <= '0;
      outValid_q <= 1'b0;
`ifdef DECIM_AVG_EN
      sumAcc_q   <= '0;
`endif
    end else begin
      count_q    <= count_d;
      ratioL_q   <= ratioL_d;
      modeL_q    <= modeL_d;
      maxAcc_q   <= maxAcc_d;
      minAcc_q   <= minAcc_d;
      result_q   <= result_d;
      outValid_q <= outValid_d;
`ifdef DECIM_AVG_EN
      sumAcc_q   <= sumAcc_d;
`endif
    end
  end

endmodule

// File: tb/tb_sample_decimator.sv
// Testbench for sample_decimator: directed scenarios followed by randomized
// traffic, all checked against a queue-based window model.
module tb_sample_decimator;

  localparam int N        = 12;
  localparam int CH       = 2;
  localparam int RW       = 16;
  localparam int MAX_LOG2 = 8;
  localparam int W        = CH * N;

  typedef logic [W-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid;
  logic [W-1:0]  d;
  logic [RW-1:0] ratio;
  logic [1:0]    mode;
  logic          hold;
  logic          outValid;
  logic [W-1:0]  q;
  logic          busy;

  int checks = 0;
  int passes = 0;

  // Reference model state: samples of the open window and its parameters
  word_t win[$];
  int    wRatio = 0;
  int    wMode  = 0;
  word_t expQ   = '0;
  logic  expValid = 1'b0;

  sample_decimator #(.N(N), .CH(CH), .RW(RW), .MAX_LOG2(MAX_LOG2)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .d(d), .ratio(ratio),
    .mode(mode), .hold(hold), .out_valid(outValid), .q(q), .busy(busy)
  );

  // Free-running sample clock
  always #5 clk = ~clk;

  function automatic word_t pack2(input int ch0, input int ch1);
    word_t w;
    w = '0;
    w[N-1:0]   = N'(ch0);
    w[2*N-1:N] = N'(ch1);
    return w;
  endfunction

  function automatic int windowLen(input int r, input int m);
`ifdef DECIM_AVG_EN
    if (m == 3) return 1 << ((r > MAX_LOG2) ? MAX_LOG2 : r);
`endif
    return (r == 0) ? 1 : r;
  endfunction

  function automatic word_t reduceWindow(input int r, input int m);
    word_t  res;
    word_t  w;
    int     v, mx, mn, last;
    longint sum;
    res = '0;
    for (int c = 0; c < CH; c++) begin
      mx = 0; mn = (1 << N) - 1; sum = 0; last = 0;
      foreach (win[i]) begin
        w = win[i];
        v = int'(w[c*N +: N]);
        if (v > mx) mx = v;
        if (v < mn) mn = v;
        sum += v;
        last = v;
      end
      case (m)
        1: res[c*N +: N] = N'(mx);
        2: res[c*N +: N] = N'(mn);
`ifdef DECIM_AVG_EN
        3: res[c*N +: N] = N'(sum / windowLen(r, m));
`endif
        default: res[c*N +: N] = N'(last);
      endcase
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic modelStep(input bit rst, input bit v, input word_t dv,
                           input int r, input int m, input bit h);
    if (rst) begin
      win.delete();
      expQ     = '0;
      expValid = 1'b0;
    end else begin
      expValid = 1'b0;
      if (v) begin
        if (win.size() == 0) begin
          wRatio = r;
          wMode  = m;
        end
        win.push_back(dv);
        if (win.size() == windowLen(wRatio, wMode)) begin
          if (!h) begin
            expQ     = reduceWindow(wRatio, wMode);
            expValid = 1'b1;
          end
          win.delete();
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input word_t dv,
                               input int r, input int m, input bit h);
    reset   = rst;
    inValid = v;
    d       = dv;
    ratio   = RW'(r);
    mode    = 2'(m);
    hold    = h;
    @(posedge clk);
    modelStep(rst, v, dv, r, m, h);
    #1;
    checkOutput("out_valid", 64'(outValid), 64'(expValid));
    checkOutput("q", 64'(q), 64'(expQ));
    checkOutput("busy", 64'(busy), 64'(win.size() != 0));
  endtask

  initial begin
    int r, m;
    bit h;
    // Reset state
    applyStimulus(1, 0, '0, 4, 0, 0);
    applyStimulus(1, 1, pack2(7, 7), 4, 0, 0);
    checkOutput("resetQ", 64'(q), 64'd0);

    // Last-sample mode, ratio 4, continuous valid
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, pack2(i, 100 + i), 4, 0, 0);
      if (i == 4) checkOutput("t1q4", 64'(q[N-1:0]), 64'd4);
    end
    checkOutput("t1q8", 64'(q[N-1:0]), 64'd8);

    // Max then min over the same three samples
    applyStimulus(0, 1, pack2(5, 7), 3, 1, 0);
    applyStimulus(0, 1, pack2(9, 1), 3, 1, 0);
    applyStimulus(0, 1, pack2(2, 3), 3, 1, 0);
    checkOutput("t2max", 64'(q), 64'(pack2(9, 7)));
    applyStimulus(0, 1, pack2(5, 7), 3, 2, 0);
    applyStimulus(0, 1, pack2(9, 1), 3, 2, 0);
    applyStimulus(0, 1, pack2(2, 3), 3, 2, 0);
    checkOutput("t2min", 64'(q), 64'(pack2(2, 1)));

    // Ratio 0 and 1 with gapped valid: pass-through, idle cycles do nothing
    for (int i = 0; i < 12; i++)
      applyStimulus(0, i[0], pack2(30 + i, 60 + i), (i < 6) ? 0 : 1, 0, 0);

    // Hold across two closes, release, then reset mid-window
    applyStimulus(0, 1, pack2(11, 12), 2, 0, 0);
    applyStimulus(0, 1, pack2(13, 14), 2, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, pack2(200 + i, 300 + i), 2, 0, 1);
    checkOutput("t4hold", 64'(q), 64'(pack2(13, 14)));
    applyStimulus(0, 1, pack2(21, 22), 2, 0, 0);
    applyStimulus(0, 1, pack2(23, 24), 2, 0, 0);
    applyStimulus(0, 1, pack2(25, 26), 2, 0, 0);
    applyStimulus(1, 1, pack2(27, 28), 2, 0, 0);
    checkOutput("t4rstBusy", 64'(busy), 64'd0);

    // Ratio changed mid-window
    applyStimulus(0, 1, pack2(1, 1), 4, 0, 0);
    for (int i = 2; i <= 8; i++) applyStimulus(0, 1, pack2(i, i), 2, 0, 0);

    // Mode 11 with ratio 2
    applyStimulus(1, 0, '0, 2, 3, 0);
    applyStimulus(0, 1, pack2(10, 0), 2, 3, 0);
    applyStimulus(0, 1, pack2(11, 0), 2, 3, 0);
    applyStimulus(0, 1, pack2(12, 0), 2, 3, 0);
    applyStimulus(0, 1, pack2(14, 0), 2, 3, 0);
`ifdef DECIM_AVG_EN
    checkOutput("t6avg", 64'(q[N-1:0]), 64'd11);
`else
    checkOutput("t6last", 64'(q[N-1:0]), 64'd14);
`endif

    // Randomized traffic with mid-window ratio/mode changes, hold and reset
    r = 3; m = 0; h = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 5);
      if ($urandom_range(0, 15) == 0) m = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) h = ~h;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                    word_t'($urandom), r, m, h);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
